// File: rtl/packet_pkg.sv
// ---------------------------------------------------------------------------
// packet_pkg : shared switch constants and output-arbiter types
// Rev 1.1    : arbiter state type and stall limit added
// ---------------------------------------------------------------------------
`default_nettype none

package packet_pkg;

  localparam int ADDR_WIDTH   = 4;
  localparam int PACKET_WIDTH = 32;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int ARB_STALL_LIMIT = 16;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin search, first set mask bit at/after ptr
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter  int NUM_PORTS = 4,
  localparam int SEL_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] mask,
  input  logic [SEL_W-1:0]     ptr,
  output logic [SEL_W-1:0]     idx,
  output logic                 any
);

  int               pos;
  logic [SEL_W-1:0] pos_sel;

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    idx     = '0;
    any     = 1'b0;
    pos     = 0;
    pos_sel = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_PORTS) begin
        pos = pos - NUM_PORTS;
      end
      pos_sel = SEL_W'(pos);
      if (mask[pos_sel]) begin
        idx = pos_sel;
        any = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/output_arbiter.sv
// ---------------------------------------------------------------------------
// output_arbiter : per-output round-robin arbiter with downstream stall flag
// Rev 1.0        : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module output_arbiter
  import packet_pkg::*;
#(
  parameter  int NUM_PORTS   = ADDR_WIDTH,
  parameter  int STALL_LIMIT = ARB_STALL_LIMIT,
  localparam int SEL_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int CNT_W       = $clog2(STALL_LIMIT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 out_ready,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [SEL_W-1:0]     mux_sel,
  output logic                 arb_active,
  output logic                 stall_err
);

  arb_state_t           state;
  logic [SEL_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]     stall_cnt;

  logic [NUM_PORTS-1:0] sel_onehot;
  logic [SEL_W-1:0]     next_ptr;
  logic                 head_req;
  logic                 pop;
  logic [NUM_PORTS-1:0] pick_mask;
  logic [SEL_W-1:0]     pick_ptr;
  logic [SEL_W-1:0]     pick_idx;
  logic                 pick_any;

  assign sel_onehot = NUM_PORTS'(1) << mux_sel;
  assign next_ptr   = (mux_sel == SEL_W'(NUM_PORTS - 1)) ? '0 : mux_sel + SEL_W'(1);
  assign head_req   = req[mux_sel];
  assign pop        = (state == ARB_GRANT) && out_ready && head_req;
  assign gnt        = pop ? sel_onehot : '0;
  assign arb_active = (state == ARB_GRANT);

  // One search serves both the fresh IDLE pick and the back-to-back pick,
  // where the port being popped is excluded because its req lags a cycle.
  assign pick_mask = (state == ARB_IDLE) ? req : (req & ~sel_onehot);
  assign pick_ptr  = (state == ARB_IDLE) ? rr_ptr : next_ptr;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_pick (
    .mask (pick_mask),
    .ptr  (pick_ptr),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      mux_sel   <= '0;
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else if (state == ARB_IDLE) begin
      if (pick_any) begin
        mux_sel <= pick_idx;
        state   <= ARB_GRANT;
      end
    end else begin
      if (!head_req) begin
        state     <= ARB_IDLE;
        stall_cnt <= '0;
      end else if (out_ready) begin
        rr_ptr    <= next_ptr;
        stall_cnt <= '0;
        if (pick_any) begin
          mux_sel <= pick_idx;
        end else begin
          state <= ARB_IDLE;
        end
      end else begin
        if (stall_cnt != CNT_W'(STALL_LIMIT)) begin
          stall_cnt <= stall_cnt + CNT_W'(1);
        end
        // Flag on the same edge the counter arrives at the limit.
        if (stall_cnt >= CNT_W'(STALL_LIMIT - 1)) begin
          stall_err <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_output_arbiter.sv
// ---------------------------------------------------------------------------
// tb_output_arbiter : directed scoreboard bench for output_arbiter
// Rev 1.0           : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_output_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;
  logic [3:0] gnt;
  logic [1:0] mux_sel;
  logic       arb_active;
  logic       stall_err;

  int checks   = 0;
  int failures = 0;
  int pop_cnt  = 0;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       act;
    logic       err;
  } exp_t;

  exp_t sb[$];

  output_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .out_ready  (out_ready),
    .gnt        (gnt),
    .mux_sel    (mux_sel),
    .arb_active (arb_active),
    .stall_err  (stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs for that cycle,
  // then compare them at the falling edge before the next rising edge.
  task automatic cyc(input logic [3:0] r, input logic rdy, input logic [3:0] eg,
                     input logic [1:0] es, input logic ea, input logic ee, input string tag);
    exp_t e;
    req       = r;
    out_ready = rdy;
    e.tag = tag;
    e.gnt = eg;
    e.sel = es;
    e.act = ea;
    e.err = ee;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, "_gnt"}, 32'(gnt), 32'(e.gnt));
    check({e.tag, "_sel"}, 32'(mux_sel), 32'(e.sel));
    check({e.tag, "_act"}, 32'(arb_active), 32'(e.act));
    check({e.tag, "_err"}, 32'(stall_err), 32'(e.err));
    check({e.tag, "_onehot"}, 32'($countones(gnt) <= 1), 32'd1);
    if (gnt != 4'b0) pop_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_act"}, 32'(arb_active), 32'd0);
    check({tag, "_sel"}, 32'(mux_sel), 32'd0);
    check({tag, "_err"}, 32'(stall_err), 32'd0);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 4'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state, then enter GRANT on port 1 and reset mid-stall
    cyc(4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_idle");
    cyc(4'b0010, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b0, "pre_rst_grant");
    async_reset("mid_grant_rst");
    cyc(4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "post_rst_idle");
    cyc(4'b1111, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, "first_grant_p0");

    // Full rotation, back-to-back
    cyc(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, "rot0");
    cyc(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, "rot1");
    cyc(4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, "rot2");
    cyc(4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, "rot3");
    cyc(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, "rot4");
    cyc(4'b0000, 1'b1, 4'b0000, 2'd1, 1'b1, 1'b0, "rot_withdraw");
    cyc(4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, "rot_idle");

    // Lone requester on port 2: served every other cycle
    pop_cnt = 0;
    cyc(4'b0100, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, "lone_i0");
    cyc(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, "lone_g0");
    cyc(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, "lone_i1");
    cyc(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, "lone_g1");
    cyc(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, "lone_i2");
    cyc(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, "lone_g2");
    cyc(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, "lone_done");
    check("lone_pops", 32'(pop_cnt), 32'd3);

    // Stall on port 1 for the full limit, then a single pop
    cyc(4'b0010, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, "stall_idle");
    for (int k = 1; k <= 16; k++) begin
      cyc(4'b0010, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b0, $sformatf("stall_%0d", k));
    end
    cyc(4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, "stall_release");
    cyc(4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b1, "stall_sticky");

    // Withdrawal on port 3 keeps rr_ptr at 2
    cyc(4'b1000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1, "wd_idle");
    cyc(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b1, 1'b1, "wd_drop");
    cyc(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b1, "wd_after");
    cyc(4'b1101, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b1, "wd_repick_idle");
    cyc(4'b1101, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, "wd_repick_p2");

    // Pop port 3 with rr_ptr wrap
    cyc(4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, "wrap_pop3");
    cyc(4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, "wrap_pop0");
    cyc(4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, "wrap_idle");
    cyc(4'b1111, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b1, "wrap_next_p1");

    // Reset clears sticky error; pop clears stall count
    async_reset("err_rst");
    cyc(4'b0011, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "cnt_idle");
    for (int k = 1; k <= 10; k++) begin
      cyc(4'b0011, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, $sformatf("cnt_a%0d", k));
    end
    cyc(4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, "cnt_pop");
    for (int k = 1; k <= 16; k++) begin
      cyc(4'b0010, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b0, $sformatf("cnt_b%0d", k));
    end
    cyc(4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, "cnt_limit");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
